fpga_spi_cmd: RTL

FPGA_SPI_CMD -- requirements
Module: fpga_spi_cmd

---
 rtl/fpga_spi_cmd.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fpga_spi_cmd.sv
// fpga_spi_cmd: ARM-facing SPI command slave clocked by pck0.
// Receives 16-bit frames (4-bit opcode, 8-bit payload in [7:0]) and updates the
// configuration word or the clock divisor. Malformed frames set a sticky error flag.
// Optional readback of conf_word on miso is enabled with macro FPGA_SPI_READBACK_EN.
module fpga_spi_cmd (
    input  logic       pck0,
    input  logic       reset,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    output logic       miso,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic       conf_strobe,
    output logic       div_strobe,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DECODE    = 2'd3
    } state_t;

    // Two synchronizer flops per input plus one/two history stages for edge detection.
    logic       r_spck_s1, r_spck_s2, r_spck_d, r_spck_d2;
    logic       r_mosi_s1, r_mosi_s2, r_mosi_d;
    logic       r_ncs_s1, r_ncs_s2, r_ncs_d, r_ncs_d2;

    state_t     r_state;
    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_conf_word;
    logic [7:0]  r_divisor;
    logic        r_conf_strobe;
    logic        r_div_strobe;
    logic        r_frame_err;

    logic w_spck_rise, w_spck_fall, w_ncs_rise, w_ncs_fall;

    // Edges are taken one stage after the synchronizer so mosi stays aligned with spck.
    assign w_spck_rise =  r_spck_d & ~r_spck_d2;
    assign w_spck_fall = ~r_spck_d &  r_spck_d2;
    assign w_ncs_rise  =  r_ncs_d  & ~r_ncs_d2;
    assign w_ncs_fall  = ~r_ncs_d  &  r_ncs_d2;

    assign conf_word   = r_conf_word;
    assign divisor     = r_divisor;
    assign conf_strobe = r_conf_strobe;
    assign div_strobe  = r_div_strobe;
    assign frame_err   = r_frame_err;

`ifdef FPGA_SPI_READBACK_EN
    logic [15:0] r_rb;
    logic        r_miso;
    logic [15:0] w_rb_load;

    assign w_rb_load = {4'b0001, 4'b0000, r_conf_word};
    assign miso      = r_miso;
`else
    assign miso = 1'b0;
`endif

    // Synchronize the asynchronous SPI inputs and keep a short history for edge detection.
    always_ff @(posedge pck0) begin
        if (reset) begin
            r_spck_s1 <= 1'b0;
            r_spck_s2 <= 1'b0;
            r_spck_d  <= 1'b0;
            r_spck_d2 <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_mosi_d  <= 1'b0;
            r_ncs_s1  <= 1'b1;
            r_ncs_s2  <= 1'b1;
            r_ncs_d   <= 1'b1;
            r_ncs_d2  <= 1'b1;
        end else begin
            r_spck_s1 <= spck;
            r_spck_s2 <= r_spck_s1;
            r_spck_d  <= r_spck_s2;
            r_spck_d2 <= r_spck_d;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_mosi_d  <= r_mosi_s2;
            r_ncs_s1  <= ncs;
            r_ncs_s2  <= r_ncs_s1;
            r_ncs_d   <= r_ncs_s2;
            r_ncs_d2  <= r_ncs_d;
        end
    end

    // Frame FSM: shift in bits while ncs is low, decode once ncs rises, drive registered outputs.
    always_ff @(posedge pck0) begin
        if (reset) begin
            r_state       <= WAIT_IDLE;
            r_shift       <= 16'h0000;
            r_bit_cnt     <= 5'd0;
            r_conf_word   <= 8'hE0;
            r_divisor     <= 8'd95;
            r_conf_strobe <= 1'b0;
            r_div_strobe  <= 1'b0;
            r_frame_err   <= 1'b0;
`ifdef FPGA_SPI_READBACK_EN
            r_rb          <= 16'h0000;
            r_miso        <= 1'b0;
`endif
        end else begin
            r_conf_strobe <= 1'b0;
            r_div_strobe  <= 1'b0;
            case (r_state)
                WAIT_IDLE: begin
                    // Wait for ncs high so a frame already running at reset release is dropped.
                    if (r_ncs_s2) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT_IDLE;
                    end
                end
                IDLE: begin
                    if (w_ncs_fall) begin
                        r_state   <= SHIFT;
                        r_shift   <= 16'h0000;
                        r_bit_cnt <= 5'd0;
`ifdef FPGA_SPI_READBACK_EN
                        r_rb      <= w_rb_load;
                        r_miso    <= w_rb_load[15];
`endif
                    end
                end
                SHIFT: begin
                    // An spck edge coinciding with the ncs rise is not part of the frame.
                    if (w_ncs_rise) begin
                        r_state <= DECODE;
`ifdef FPGA_SPI_READBACK_EN
                        r_miso  <= 1'b0;
`endif
                    end else begin
                        if (w_spck_rise) begin
                            r_shift <= {r_shift[14:0], r_mosi_d};
                            if (r_bit_cnt != 5'd17) begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
`ifdef FPGA_SPI_READBACK_EN
                        if (w_spck_fall) begin
                            r_rb   <= {r_rb[14:0], 1'b0};
                            r_miso <= r_rb[14];
                        end
`endif
                    end
                end
                DECODE: begin
                    r_state <= IDLE;
                    if (r_bit_cnt == 5'd16) begin
                        case (r_shift[15:12])
                            4'b0001: begin
                                r_conf_word   <= r_shift[7:0];
                                r_conf_strobe <= 1'b1;
                            end
                            4'b0010: begin
                                r_divisor    <= r_shift[7:0];
                                r_div_strobe <= 1'b1;
                            end
                            default: begin
                                r_conf_word <= r_conf_word;
                            end
                        endcase
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= WAIT_IDLE;
                end
            endcase
        end
    end

endmodule
